// File: rtl/rs232_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_pkg
//  Description : Shared types and helpers for the RS232 receive/transmit
//                sequencers: FSM state encoding, default bit period and the
//                bit-period counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs232_pkg;

  // Default bit period: 50 MHz reference clock, 115200 baud.
  localparam int c_DEFAULT_BAUD_DIV = 434;

  // Receive FSM states, explicitly encoded in 3 bits.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  // Width of a counter that spans 0 .. div-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int div);
    if (div <= 2) begin
      return 1;
    end
    return $clog2(div);
  endfunction

endpackage : rs232_pkg
`default_nettype wire

// File: rtl/rs232_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_bit_timer
//  Description : Free-running bit-period counter. Counts 0 .. BAUD_DIV-1 and
//                wraps; i_clr forces it back to 0. Flags the half-bit and
//                full-bit terminal counts so a sequencer can place its
//                mid-bit sample points.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs232_bit_timer
  import rs232_pkg::*;
#(
  parameter int BAUD_DIV = c_DEFAULT_BAUD_DIV
) (
  input  logic clk_ref,
  input  logic rst,
  input  logic i_clr,
  output logic o_half,
  output logic o_full
);

  localparam int              c_CW      = cnt_width(BAUD_DIV);
  localparam logic [c_CW-1:0] c_HALF_TC = c_CW'(BAUD_DIV / 2 - 1);
  localparam logic [c_CW-1:0] c_FULL_TC = c_CW'(BAUD_DIV - 1);

  logic [c_CW-1:0] r_cnt;

  // Counter: cleared on request, otherwise increments and wraps at the full count.
  always_ff @(posedge clk_ref) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == c_FULL_TC) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CW'(1);
    end
  end

  assign o_half = (r_cnt == c_HALF_TC);
  assign o_full = (r_cnt == c_FULL_TC);

endmodule : rs232_bit_timer
`default_nettype wire

// File: rtl/rs232_rx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_rx_sequencer
//  Description : RS232 receive controller. Synchronises the serial line,
//                validates the start bit at mid-bit, emits exactly eight
//                one-cycle bit strobes per frame for the downstream serial
//                demux, checks optional parity and the stop bit, and reports
//                frame status with a copy of the received byte. A stop bit
//                read low parks the receiver in BREAK until the line rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs232_rx_sequencer
  import rs232_pkg::*;
#(
  parameter int BAUD_DIV   = c_DEFAULT_BAUD_DIV,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk_ref,
  input  logic       rst,
  input  logic       i_rx_en,
  input  logic       i_rx_di,
  output logic       o_rcpt_en,
  output logic       o_rcpt_di,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic [7:0] o_byte_q,
  output logic       o_break_det
);

  // Line synchroniser (idle level is high, so it resets to 1).
  logic r_sync1;
  logic r_sync2;
  logic w_rx_s;

  // FSM.
  rx_state_t r_state;
  rx_state_t w_state_nxt;

  // Timer interface and per-state sample decodes.
  logic w_half;
  logic w_full;
  logic w_tmr_clr;
  logic w_smp_data;
  logic w_smp_par;
  logic w_smp_stop;

  // Frame datapath.
  logic [2:0] r_bit_idx;
  logic [7:0] r_shadow;
  logic       r_xor;
  logic       r_par_err;

  // Registered outputs.
  logic       r_rcpt_en;
  logic       r_rcpt_di;
  logic       r_frame_done;
  logic       r_frame_err;
  logic       r_parity_err;
  logic [7:0] r_byte_q;

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx_di;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  rs232_bit_timer #(
    .BAUD_DIV (BAUD_DIV)
  ) u_bit_timer (
    .clk_ref (clk_ref),
    .rst     (rst),
    .i_clr   (w_tmr_clr),
    .o_half  (w_half),
    .o_full  (w_full)
  );

  // State register.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: start validation at mid-bit, then one bit per period.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_rx_en && !w_rx_s) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_half) begin
          w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_full && (r_bit_idx == 3'd7)) begin
          w_state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_full) begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_full) begin
          w_state_nxt = w_rx_s ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (w_rx_s) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode: timer clearing and the per-state mid-bit sample strobes.
  always_comb begin
    w_tmr_clr  = 1'b0;
    w_smp_data = 1'b0;
    w_smp_par  = 1'b0;
    w_smp_stop = 1'b0;
    case (r_state)
      ST_IDLE:   w_tmr_clr  = 1'b1;
      ST_START:  w_tmr_clr  = w_half;   // realign so DATA starts counting from 0
      ST_DATA:   w_smp_data = w_full;
      ST_PARITY: w_smp_par  = w_full;
      ST_STOP:   w_smp_stop = w_full;
      ST_BREAK:  w_tmr_clr  = 1'b1;
      default:   w_tmr_clr  = 1'b1;
    endcase
  end

  // Frame datapath: bit strobes, byte shadow, parity accumulation and status.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      r_bit_idx    <= 3'd0;
      r_shadow     <= 8'h00;
      r_xor        <= 1'b0;
      r_par_err    <= 1'b0;
      r_rcpt_en    <= 1'b0;
      r_rcpt_di    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_byte_q     <= 8'h00;
    end else begin
      r_rcpt_en    <= w_smp_data;
      r_frame_done <= w_smp_stop;

      if (r_state == ST_START) begin
        r_bit_idx <= 3'd0;
        r_xor     <= 1'b0;
        r_par_err <= 1'b0;
      end

      if (w_smp_data) begin
        r_rcpt_di           <= w_rx_s;
        r_shadow[r_bit_idx] <= w_rx_s;
        r_xor               <= r_xor ^ w_rx_s;
        r_bit_idx           <= r_bit_idx + 3'd1;
      end

      if (w_smp_par) begin
        r_par_err <= ((r_xor ^ w_rx_s) != PARITY_ODD);
      end

      if (w_smp_stop) begin
        r_byte_q     <= r_shadow;
        r_frame_err  <= ~w_rx_s;
        r_parity_err <= PARITY_EN && r_par_err;
      end
    end
  end

  assign o_rcpt_en    = r_rcpt_en;
  assign o_rcpt_di    = r_rcpt_di;
  assign o_frame_done = r_frame_done;
  assign o_frame_err  = r_frame_err;
  assign o_parity_err = r_parity_err;
  assign o_byte_q     = r_byte_q;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_break_det  = (r_state == ST_BREAK);

endmodule : rs232_rx_sequencer
`default_nettype wire

// File: tb/tb_rs232_rx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs232_rx_sequencer
//  Description : Bench for rs232_rx_sequencer. Two instances (no parity and
//                even parity) are driven with directed serial frames. A
//                frame-level model (expected bit and frame queues, a demux
//                shift model) is checked against the outputs every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs232_rx_sequencer;

  localparam int   BAUD    = 8;
  localparam logic PAR_ODD = 1'b0;

  typedef struct packed {
    logic [7:0] b;
    logic       ferr;
    logic       perr;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       rx_en      [2];
  logic       rx_di      [2];
  logic       rcpt_en    [2];
  logic       rcpt_di    [2];
  logic       busy       [2];
  logic       frame_done [2];
  logic       frame_err  [2];
  logic       parity_err [2];
  logic       break_det  [2];
  logic [7:0] byte_q     [2];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Model state per instance.
  logic       bitq [2][$];
  frame_t     frq  [2][$];
  logic [7:0] held_b  [2];
  logic       held_fe [2];
  logic       held_pe [2];
  logic [7:0] dm_sr   [2];
  logic [7:0] dm_q    [2];
  int strb_tot [2];
  int done_tot [2];
  int dv_tot   [2];
  int done_cyc [2];
  int last_strb[2];
  int sidx     [2];
  int dm_cnt   [2];
  int t_fall   [2];

  always #5 clk = ~clk;

  rs232_rx_sequencer #(
    .BAUD_DIV   (BAUD),
    .PARITY_EN  (1'b0),
    .PARITY_ODD (1'b0)
  ) dut0 (
    .clk_ref      (clk),
    .rst          (rst),
    .i_rx_en      (rx_en[0]),
    .i_rx_di      (rx_di[0]),
    .o_rcpt_en    (rcpt_en[0]),
    .o_rcpt_di    (rcpt_di[0]),
    .o_busy       (busy[0]),
    .o_frame_done (frame_done[0]),
    .o_frame_err  (frame_err[0]),
    .o_parity_err (parity_err[0]),
    .o_byte_q     (byte_q[0]),
    .o_break_det  (break_det[0])
  );

  rs232_rx_sequencer #(
    .BAUD_DIV   (BAUD),
    .PARITY_EN  (1'b1),
    .PARITY_ODD (PAR_ODD)
  ) dut1 (
    .clk_ref      (clk),
    .rst          (rst),
    .i_rx_en      (rx_en[1]),
    .i_rx_di      (rx_di[1]),
    .o_rcpt_en    (rcpt_en[1]),
    .o_rcpt_di    (rcpt_di[1]),
    .o_busy       (busy[1]),
    .o_frame_done (frame_done[1]),
    .o_frame_err  (frame_err[1]),
    .o_parity_err (parity_err[1]),
    .o_byte_q     (byte_q[1]),
    .o_break_det  (break_det[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Per-cycle comparison of one instance against the frame-level model.
  task automatic check_cycle(input int d);
    frame_t f;
    logic   e;
    if (rst) begin
      sidx[d]    = 0;
      dm_cnt[d]  = 0;
      held_b[d]  = 8'h00;
      held_fe[d] = 1'b0;
      held_pe[d] = 1'b0;
      return;
    end
    if (rcpt_en[d]) begin
      strb_tot[d]++;
      if (sidx[d] != 0) chk($sformatf("d%0d_strobe_spacing", d), cyc - last_strb[d], BAUD);
      last_strb[d] = cyc;
      sidx[d]      = (sidx[d] + 1) % 8;
      chk($sformatf("d%0d_strobe_expected", d), bitq[d].size() != 0, 1'b1);
      if (bitq[d].size() != 0) begin
        e = bitq[d].pop_front();
        chk($sformatf("d%0d_rcpt_di", d), rcpt_di[d], e);
      end
      dm_sr[d] = {rcpt_di[d], dm_sr[d][7:1]};
      dm_cnt[d]++;
      if (dm_cnt[d] == 8) begin
        dm_cnt[d] = 0;
        dv_tot[d]++;
        dm_q[d] = dm_sr[d];
        if (frq[d].size() != 0) chk($sformatf("d%0d_demux_r_q", d), dm_q[d], frq[d][0].b);
      end
    end
    if (frame_done[d]) begin
      done_tot[d]++;
      done_cyc[d] = cyc;
      chk($sformatf("d%0d_frame_expected", d), frq[d].size() != 0, 1'b1);
      if (frq[d].size() != 0) begin
        f          = frq[d].pop_front();
        held_b[d]  = f.b;
        held_fe[d] = f.ferr;
        held_pe[d] = f.perr;
      end
    end
    chk($sformatf("d%0d_byte_q", d), byte_q[d], held_b[d]);
    chk($sformatf("d%0d_frame_err", d), frame_err[d], held_fe[d]);
    chk($sformatf("d%0d_parity_err", d), parity_err[d], held_pe[d]);
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) check_cycle(d);
  end

  task automatic drive_bit(input int d, input logic v);
    rx_di[d] = v;
    repeat (BAUD) @(posedge clk);
    #1;
  endtask

  // Queue the expectations for a frame, then drive it onto the line.
  task automatic send_frame(input int d, input logic [7:0] b, input logic pen, input logic pbit,
                            input logic stop, input int nexp, input bit push_fr);
    frame_t f;
    for (int i = 0; i < nexp; i++) bitq[d].push_back(b[i]);
    if (push_fr) begin
      f.b    = b;
      f.ferr = ~stop;
      f.perr = pen ? ((^b ^ pbit) != PAR_ODD) : 1'b0;
      frq[d].push_back(f);
    end
    t_fall[d] = cyc;
    drive_bit(d, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d, b[i]);
    if (pen) drive_bit(d, pbit);
    drive_bit(d, stop);
  endtask

  task automatic wait_strobes(input int d, input int target, input int budget, input string name);
    int n = 0;
    while (strb_tot[d] < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, strb_tot[d] >= target, 1'b1);
  endtask

  task automatic check_zero(input int d, input string tag);
    chk($sformatf("%s_d%0d_rcpt_en", tag, d), rcpt_en[d], 1'b0);
    chk($sformatf("%s_d%0d_busy", tag, d), busy[d], 1'b0);
    chk($sformatf("%s_d%0d_frame_done", tag, d), frame_done[d], 1'b0);
    chk($sformatf("%s_d%0d_frame_err", tag, d), frame_err[d], 1'b0);
    chk($sformatf("%s_d%0d_parity_err", tag, d), parity_err[d], 1'b0);
    chk($sformatf("%s_d%0d_byte_q", tag, d), byte_q[d], 8'h00);
    chk($sformatf("%s_d%0d_break_det", tag, d), break_det[d], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s0, d0, dv0, nb;
    for (int d = 0; d < 2; d++) begin
      rx_en[d] = 1'b1;
      rx_di[d] = 1'b1;
      held_b[d] = 8'h00; held_fe[d] = 1'b0; held_pe[d] = 1'b0;
      dm_sr[d] = 8'h00;  dm_q[d] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_zero(0, "reset");
    check_zero(1, "reset");
    repeat (5) @(posedge clk);
    #1;

    // 1: 0xA5, stop 1, rx_en dropped mid-frame.
    s0 = strb_tot[0]; dv0 = dv_tot[0];
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 8, 1'b1);
      begin
        wait_strobes(0, s0 + 2, 100, "t1_wait_strobe2");
        rx_en[0] = 1'b0;
      end
    join
    rx_en[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t1_strobes", strb_tot[0] - s0, 8);
    chk("t1_demux_dv", dv_tot[0] - dv0, 1);
    chk("t1_demux_q", dm_q[0], 8'hA5);
    chk("t1_byte_q", byte_q[0], 8'hA5);
    chk("t1_frame_err", frame_err[0], 1'b0);
    chk_range("t1_frame_len", done_cyc[0] - t_fall[0], 76, 82);
    chk("t1_busy_idle", busy[0], 1'b0);

    // 2: 3-cycle low glitch.
    s0 = strb_tot[0]; d0 = done_tot[0]; nb = 0;
    rx_di[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) rx_di[0] = 1'b1;
      @(posedge clk);
      #1;
      if (busy[0]) nb++;
    end
    chk_range("t2_busy_cycles", nb, 1, 4);
    chk("t2_strobes", strb_tot[0] - s0, 0);
    chk("t2_frames", done_tot[0] - d0, 0);

    // 3: 0x3C with stop 0, line held low, then released.
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 8, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("t3_break_det", break_det[0], 1'b1);
    chk("t3_busy_break", busy[0], 1'b1);
    chk("t3_frame_err", frame_err[0], 1'b1);
    chk("t3_byte_q", byte_q[0], 8'h3C);
    repeat (10) @(posedge clk);
    #1;
    chk("t3_break_still", break_det[0], 1'b1);
    rx_di[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t3_break_clear", break_det[0], 1'b0);
    chk("t3_idle", busy[0], 1'b0);

    // 4: even parity instance.
    s0 = strb_tot[1];
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 8, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_parity_ok", parity_err[1], 1'b0);
    chk("t4_frame_err", frame_err[1], 1'b0);
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 8, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_parity_bad", parity_err[1], 1'b1);
    chk("t4_byte_q", byte_q[1], 8'h07);
    chk("t4_strobes", strb_tot[1] - s0, 16);

    // 5: reset after the 4th strobe of 0xFF, then 0x12.
    s0 = strb_tot[0]; d0 = done_tot[0];
    fork
      send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, 4, 1'b0);
      begin
        wait_strobes(0, s0 + 4, 100, "t5_wait_strobe4");
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_zero(0, "t5_abort");
      end
    join
    repeat (20) @(posedge clk);
    #1;
    chk("t5_strobes", strb_tot[0] - s0, 4);
    chk("t5_frames", done_tot[0] - d0, 0);
    d0 = done_tot[0];
    send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, 8, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_frames_after", done_tot[0] - d0, 1);
    chk("t5_byte_q", byte_q[0], 8'h12);

    // 6: back-to-back 0x55, 0xAA.
    s0 = strb_tot[0]; d0 = done_tot[0];
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 8, 1'b1);
    send_frame(0, 8'hAA, 1'b0, 1'b0, 1'b1, 8, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_frames", done_tot[0] - d0, 2);
    chk("t6_strobes", strb_tot[0] - s0, 16);
    chk("t6_byte_q", byte_q[0], 8'hAA);

    repeat (10) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("end_d%0d_bits_left", d), bitq[d].size(), 0);
      chk($sformatf("end_d%0d_frames_left", d), frq[d].size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_rs232_rx_sequencer
`default_nettype wire
